// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-side blocks: FSM state encoding,
//   common keyboard command/response bytes and the frame parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    // PS/2 frames carry odd parity: the parity bit makes the total count of
    // ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// ps2_host_tx_sync_edge
//   Two-flop synchronizer for one raw PS/2 pin plus a last-value register
//   producing a one-cycle falling-edge pulse. Shared with the PS/2 receiver.
//   All flops reset to 1 (idle bus level) so no spurious edge follows reset.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high
//   i_pin    raw asynchronous pin level
//   o_sync   synchronized pin level
//   o_fall   one-cycle pulse on a synchronized 1 -> 0 transition
module ps2_host_tx_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_last <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_last <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_last & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one byte using the open-drain
//   request-to-send sequence and reports ACK / timeout. The oe outputs are
//   pull-low enables; the board level turns them into pin = oe ? 0 : 'z.
// Ports:
//   i_clk, i_reset       system clock, synchronous active-high reset
//   i_tx_data/i_tx_start byte to send and its request (taken only when ready)
//   o_tx_ready           idle, can accept a byte
//   o_tx_done            one-cycle pulse at the end of every transfer
//   o_tx_ack_ok          valid with o_tx_done: ACK seen and no timeout
//   o_tx_error           sticky failure flag, cleared by the next accepted start
//   o_rx_inhibit         high while not idle so the receiver ignores the bus
//   i_ps2_clk_in/data_in raw pin reads
//   o_ps2_clk_oe/data_oe 1 = pull the line low
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus released, waiting for i_tx_start
// INHIBIT    | clock held low for INHIBIT_CYCLES
// REQ        | clock still low, data pulled low (start bit), one cycle
// SEND       | clock released; present next bit after each device fall
// WAIT_IDLE  | ACK sampled at fall 11; wait for clock and data both high
// DONE       | one-cycle result pulse
//
// INHIBIT_CYCLES, FIRST_CLK_TIMEOUT and BIT_TIMEOUT must all be >= 1.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES    = 12000,
    parameter int unsigned FIRST_CLK_TIMEOUT = 1500000,
    parameter int unsigned BIT_TIMEOUT       = 200000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_ack_ok,
    output logic       o_tx_error,
    output logic       o_rx_inhibit,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > FIRST_CLK_TIMEOUT) ?
                                      INHIBIT_CYCLES : FIRST_CLK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > BIT_TIMEOUT) ? MAX_AB : BIT_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Down-counter reload values; terminal count is zero, so loading N-1
    // gives exactly N cycles in the state.
    localparam logic [CNT_W-1:0] LD_INH   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_FIRST = CNT_W'(FIRST_CLK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_BIT   = CNT_W'(BIT_TIMEOUT - 1);

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_unused_data_fall;

    ps2_host_tx_sync_edge u_sync_clk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pin   (i_ps2_clk_in),
        .o_sync  (w_clk_sync),
        .o_fall  (w_clk_fall)
    );

    ps2_host_tx_sync_edge u_sync_data (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pin   (i_ps2_data_in),
        .o_sync  (w_data_sync),
        .o_fall  (w_unused_data_fall)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_parity;
    logic             r_ack;
    logic             r_ready;
    logic             r_done;
    logic             r_ack_ok;
    logic             r_error;
    logic             r_rx_inh;
    logic             r_clk_oe;
    logic             r_data_oe;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_ack     <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_error   <= 1'b0;
            r_rx_inh  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_tx_start) begin
                        r_data    <= i_tx_data;
                        r_parity  <= odd_parity(i_tx_data);
                        r_error   <= 1'b0;
                        r_ack_ok  <= 1'b0;
                        r_ack     <= 1'b0;
                        r_bit     <= '0;
                        r_cnt     <= LD_INH;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_ready   <= 1'b0;
                        r_rx_inh  <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == '0) begin
                        r_data_oe <= 1'b1;
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_REQ: begin
                    r_clk_oe <= 1'b0;
                    r_cnt    <= LD_FIRST;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    // A fall wins over a watchdog expiry on the same cycle.
                    if (w_clk_fall) begin
                        r_bit <= r_bit + 1'b1;
                        r_cnt <= LD_BIT;
                        if (r_bit < 4'd8) begin
                            r_data_oe <= ~r_data[r_bit[2:0]];
                        end else if (r_bit == 4'd8) begin
                            r_data_oe <= ~r_parity;
                        end else if (r_bit == 4'd9) begin
                            r_data_oe <= 1'b0;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_ack     <= ~w_data_sync;
                            r_state   <= ST_WAIT_IDLE;
                        end
                    end else if (r_cnt == '0) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_done    <= 1'b1;
                        r_ack_ok  <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_clk_sync && w_data_sync) begin
                        r_done   <= 1'b1;
                        r_ack_ok <= r_ack;
                        r_error  <= ~r_ack;
                        r_state  <= ST_DONE;
                    end else if (w_clk_fall) begin
                        r_cnt <= LD_BIT;
                    end else if (r_cnt == '0) begin
                        r_done   <= 1'b1;
                        r_ack_ok <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ready  <= 1'b1;
                    r_rx_inh <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_ready   <= 1'b1;
                    r_rx_inh  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready    = r_ready;
    assign o_tx_done     = r_done;
    assign o_tx_ack_ok   = r_ack_ok;
    assign o_tx_error    = r_error;
    assign o_rx_inhibit  = r_rx_inh;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH   = 40;
    localparam int FIRST = 1000;
    localparam int BITTO = 200;
    localparam int H     = 20;   // device half clock period in system cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready, tx_done, tx_ack_ok, tx_error, rx_inhibit;
    logic       clk_oe, data_oe;
    logic       dev_clk, dev_data;

    // Open-drain buses: either side may pull low.
    wire ps2_clk_line  = dev_clk  & ~clk_oe;
    wire ps2_data_line = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .FIRST_CLK_TIMEOUT (FIRST),
        .BIT_TIMEOUT       (BITTO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_tx_data     (tx_data),
        .i_tx_start    (tx_start),
        .o_tx_ready    (tx_ready),
        .o_tx_done     (tx_done),
        .o_tx_ack_ok   (tx_ack_ok),
        .o_tx_error    (tx_error),
        .o_rx_inhibit  (rx_inhibit),
        .i_ps2_clk_in  (ps2_clk_line),
        .i_ps2_data_in (ps2_data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    int total = 0;
    int bad   = 0;
    int done_total = 0;

    always @(posedge clk) if (tx_done === 1'b1) done_total <= done_total + 1;

    // results of the latest device run / done wait
    logic [9:0] m_got;
    bit         m_seen;
    int         m_cyc, m_inh, m_both;
    logic       m_ack, m_err, m_rdy_nx, m_done_nx;
    logic [1:0] m_oe;

    // Expected on-wire bits after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic start_xfer(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, clocks 11 falls, reads each
    // bit during the high phase, optionally ACKs at fall 11.
    task automatic dev_run(input int stop_fall, input bit do_ack);
        int n = 0;
        m_got = '0;
        while (n < INH + 20 && !(clk_oe == 1'b0 && ps2_data_line == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= INH + 20) begin
            bad++;
            $display("FAIL dev_request: got no request, need one within %0d cycles", INH + 20);
            return;
        end
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            if (k == stop_fall) begin
                repeat (6) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H / 2) @(negedge clk);
            if (k <= 10) m_got[k-1] = ps2_data_line;
            if (k == 11) dev_data = 1'b1;
            else repeat (H / 2) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit);
        int c = 0;
        m_seen = 0; m_inh = 0; m_both = 0;
        while (c <= limit && !m_seen) begin
            if (tx_done === 1'b1) begin
                m_seen = 1;
            end else begin
                if (clk_oe && !data_oe) m_inh++;
                if (clk_oe && data_oe)  m_both++;
                @(negedge clk);
                c++;
            end
        end
        m_cyc = c;
        m_ack = tx_ack_ok;
        m_err = tx_error;
        m_oe  = {clk_oe, data_oe};
        @(negedge clk);
        m_rdy_nx  = tx_ready;
        m_done_nx = tx_done;
    endtask

    task automatic do_xfer(input logic [7:0] b, input bit ack, input string tag);
        logic [9:0] exp;
        int d0;
        exp = frame_of(b);
        d0  = done_total;
        start_xfer(b);
        fork
            dev_run(0, ack);
            wait_done(INH + FIRST + 800);
        join
        total++;
        if (!m_seen) begin
            bad++;
            $display("FAIL %s done_seen: got no pulse, need one", tag);
            return;
        end
        total++; if (m_got !== exp) begin bad++; $display("FAIL %s frame: got %b need %b", tag, m_got, exp); end
        total++; if (m_ack !== ack) begin bad++; $display("FAIL %s ack_ok: got %b need %b", tag, m_ack, ack); end
        total++; if (m_err !== !ack) begin bad++; $display("FAIL %s error: got %b need %b", tag, m_err, !ack); end
        total++; if (m_oe !== 2'b00) begin bad++; $display("FAIL %s oe_at_done: got %b need 00", tag, m_oe); end
        total++; if (m_rdy_nx !== 1'b1) begin bad++; $display("FAIL %s ready_after: got %b need 1", tag, m_rdy_nx); end
        total++; if (m_done_nx !== 1'b0) begin bad++; $display("FAIL %s done_width: got %b need 0", tag, m_done_nx); end
        total++; if (m_inh !== INH) begin bad++; $display("FAIL %s inhibit_len: got %0d need %0d", tag, m_inh, INH); end
        total++; if (m_both !== 1) begin bad++; $display("FAIL %s req_len: got %0d need 1", tag, m_both); end
        total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL %s done_count: got %0d need 1", tag, done_total - d0); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (tx_ready !== 1'b1)   begin bad++; $display("FAIL rst_ready: got %b need 1", tx_ready); end
        total++; if (tx_done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %b need 0", tx_done); end
        total++; if (tx_ack_ok !== 1'b0)  begin bad++; $display("FAIL rst_ack_ok: got %b need 0", tx_ack_ok); end
        total++; if (tx_error !== 1'b0)   begin bad++; $display("FAIL rst_error: got %b need 0", tx_error); end
        total++; if (rx_inhibit !== 1'b0) begin bad++; $display("FAIL rst_inhibit: got %b need 0", rx_inhibit); end
        total++; if ({clk_oe, data_oe} !== 2'b00) begin bad++; $display("FAIL rst_oe: got %b need 00", {clk_oe, data_oe}); end
    endtask

    task automatic test_send;
        do_xfer(CMD_SET_LED, 1'b1, "send_ed");
    endtask

    task automatic test_parity;
        do_xfer(8'h01, 1'b1, "parity_01");
        do_xfer(8'h00, 1'b1, "parity_00");
    endtask

    task automatic test_random;
        logic [7:0] pool [5];
        pool = '{CMD_SET_LED, CMD_ENABLE, CMD_RESET, RESP_ACK, RESP_RESEND};
        do_xfer(pool[$urandom_range(0, 4)], 1'b1, "rand_cmd");
        for (int t = 0; t < 4; t++)
            do_xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), "rand");
    endtask

    task automatic test_no_ack;
        do_xfer(8'($urandom_range(0, 255)), 1'b0, "no_ack");
    endtask

    task automatic test_timeout;
        start_xfer(CMD_ENABLE);
        wait_done(INH + FIRST + 50);
        total++;
        if (!m_seen) begin
            bad++;
            $display("FAIL to_done_seen: got no pulse, need one");
        end else begin
            total++; if (m_cyc !== INH + 1 + FIRST) begin bad++; $display("FAIL to_latency: got %0d need %0d", m_cyc, INH + 1 + FIRST); end
            total++; if (m_ack !== 1'b0) begin bad++; $display("FAIL to_ack_ok: got %b need 0", m_ack); end
            total++; if (m_err !== 1'b1) begin bad++; $display("FAIL to_error: got %b need 1", m_err); end
            total++; if (m_oe !== 2'b00) begin bad++; $display("FAIL to_oe: got %b need 00", m_oe); end
            total++; if (m_rdy_nx !== 1'b1) begin bad++; $display("FAIL to_ready_after: got %b need 1", m_rdy_nx); end
        end
        repeat (3) @(negedge clk);
        total++; if (tx_error !== 1'b1) begin bad++; $display("FAIL to_error_sticky: got %b need 1", tx_error); end
        start_xfer(CMD_RESET);
        total++; if (tx_error !== 1'b0) begin bad++; $display("FAIL to_error_clear: got %b need 0", tx_error); end
        fork
            dev_run(0, 1'b1);
            wait_done(INH + FIRST + 800);
        join
        total++; if (!m_seen || m_ack !== 1'b1) begin bad++; $display("FAIL to_recover: got seen=%0d ack=%b need seen=1 ack=1", m_seen, m_ack); end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_total;
        start_xfer(CMD_RESET);
        dev_run(5, 1'b1);
        total++; if (rx_inhibit !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b need 1", rx_inhibit); end
        reset = 1'b1;
        @(negedge clk);
        total++; if ({clk_oe, data_oe} !== 2'b00) begin bad++; $display("FAIL mid_oe: got %b need 00", {clk_oe, data_oe}); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b need 1", tx_ready); end
        total++; if (rx_inhibit !== 1'b0) begin bad++; $display("FAIL mid_inhibit: got %b need 0", rx_inhibit); end
        reset   = 1'b0;
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (done_total !== d0) begin bad++; $display("FAIL mid_no_done: got %0d pulses need 0", done_total - d0); end
        do_xfer(CMD_RESET, 1'b1, "mid_fresh");
    endtask

    task automatic test_ignore_start;
        logic [7:0] b;
        int d0;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'hAA;
        d0 = done_total;
        start_xfer(b);
        fork
            dev_run(0, 1'b1);
            wait_done(INH + FIRST + 800);
            begin
                repeat (INH + 30) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        total++; if (m_got !== frame_of(b)) begin bad++; $display("FAIL ign_frame: got %b need %b", m_got, frame_of(b)); end
        total++; if (m_ack !== 1'b1) begin bad++; $display("FAIL ign_ack_ok: got %b need 1", m_ack); end
        repeat (50) @(negedge clk);
        total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL ign_done_count: got %0d need 1", done_total - d0); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL ign_idle: got %b need 1", tx_ready); end
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        test_reset;
        test_send;
        test_parity;
        test_random;
        test_no_ack;
        test_timeout;
        test_reset_mid;
        test_ignore_start;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
